// File: rtl/truth_table_checker.sv
// Walks every input row of a combinational block and checks its output.
// Reports pass/fail, the first bad row, its value and the mismatch count.
module truth_table_checker #(
  parameter int                   N_IN         = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECTED     = 4'b1011,
  parameter int                   SETTLE       = 2,
  parameter bit                   STOP_ON_FAIL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN-1:0] fail_row,
  output logic            fail_got,
  output logic [N_IN:0]   err_cnt
);

  localparam int ROWS = 1 << N_IN;

  localparam logic [N_IN-1:0] LAST = N_IN'(ROWS - 1);
  localparam logic [N_IN:0]   SAT  = (N_IN+1)'(ROWS);
  localparam logic [7:0]      CNT0 = 8'(SETTLE - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]      state;
  logic [N_IN-1:0] row;
  logic [7:0]      cnt;
  logic            mism;
  logic            last;
  logic [N_IN:0]   err_nxt;

  always_comb begin
    mism    = dut_out != EXPECTED[row];
    last    = row == LAST;
    err_nxt = err_cnt;
    if (mism && err_cnt != SAT)
      err_nxt = err_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      row      <= '0;
      cnt      <= '0;
      dut_in   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_row <= '0;
      fail_got <= 1'b0;
      err_cnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_DRIVE;
            row      <= '0;
            err_cnt  <= '0;
            fail_row <= '0;
            fail_got <= 1'b0;
            pass     <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_DRIVE: begin
          dut_in <= row;
          cnt    <= CNT0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == 8'd0)
            state <= S_SAMPLE;
          else
            cnt <= cnt - 8'd1;
        end
        S_SAMPLE: begin
          err_cnt <= err_nxt;
          if (mism && err_cnt == '0) begin
            fail_row <= row;
            fail_got <= dut_out;
          end
          // pass uses the count including this row's result
          if ((mism && STOP_ON_FAIL) || last) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= err_nxt == '0;
          end else begin
            row   <= row + 1'b1;
            state <= S_DRIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: three parameterisations, modelled
// combinational blocks, expected results queued per run.
module tb_truth_table_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      st;
  logic [2:0][1:0] md;
  logic [2:0][1:0] din;
  logic [2:0]      dout;
  logic [2:0]      busy;
  logic [2:0]      done;
  logic [2:0]      pass;
  logic [2:0][1:0] frow;
  logic [2:0]      fgot;
  logic [2:0][2:0] ecnt;

  // md: 0 = ~a|b, 1 = a&~b, 2 = const 0, 3 = const 1
  function automatic logic blk(input logic [1:0] m, input logic [1:0] x);
    case (m)
      2'd0: return ~x[1] | x[0];
      2'd1: return x[1] & ~x[0];
      2'd2: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  always_comb begin
    dout = '0;
    for (int i = 0; i < 3; i++) dout[i] = blk(md[i], din[i]);
  end

  truth_table_checker #(.STOP_ON_FAIL(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .dut_in(din[0]),
    .dut_out(dout[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .fail_row(frow[0]), .fail_got(fgot[0]), .err_cnt(ecnt[0]));

  truth_table_checker #(.STOP_ON_FAIL(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .dut_in(din[1]),
    .dut_out(dout[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .fail_row(frow[1]), .fail_got(fgot[1]), .err_cnt(ecnt[1]));

  truth_table_checker #(.EXPECTED(4'b0100), .STOP_ON_FAIL(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .dut_in(din[2]),
    .dut_out(dout[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .fail_row(frow[2]), .fail_got(fgot[2]), .err_cnt(ecnt[2]));

  typedef struct {
    int inst;
    int mode;
    int cyc;
    int ps;
    int row;
    int got;
    int cnt;
  } vec_t;

  vec_t tbl[9];
  vec_t sbq[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic run(input int inst, input int poke_at);
    vec_t e;
    int cyc;
    st[inst] = 1'b1;
    @(posedge clk);
    #1;
    st[inst] = 1'b0;
    chk("start_busy", busy[inst], 1);
    chk("start_clr", {done[inst], pass[inst]}, 0);
    cyc = 0;
    while (!done[inst] && cyc < 200) begin
      if (cyc == poke_at) st[inst] = 1'b1;
      @(posedge clk);
      #1;
      st[inst] = 1'b0;
      cyc++;
      if (busy[inst] && cyc % 4 == 2)
        chk("row_order", din[inst], cyc / 4);
    end
    e = sbq.pop_front();
    if (!done[inst]) begin
      tests++;
      fails++;
      $display("FAIL timeout inst=%0d got=%0d cycles exp=%0d", inst, cyc, e.cyc);
    end else begin
      chk("latency", cyc, e.cyc);
      chk("busy_end", busy[inst], 0);
      chk("pass", pass[inst], e.ps);
      chk("fail_row", frow[inst], e.row);
      chk("fail_got", fgot[inst], e.got);
      chk("err_cnt", ecnt[inst], e.cnt);
    end
  endtask

  initial begin
    st = '0;
    md = '0;
    tbl[0] = '{0, 0, 16, 1, 0, 0, 0};
    tbl[1] = '{0, 1,  4, 0, 0, 0, 1};
    tbl[2] = '{2, 1, 16, 1, 0, 0, 0};
    tbl[3] = '{2, 2, 16, 0, 2, 0, 1};
    tbl[4] = '{1, 3, 16, 0, 2, 1, 1};
    tbl[5] = '{1, 1, 16, 0, 0, 0, 4};
    tbl[6] = '{1, 2, 16, 0, 0, 0, 3};
    tbl[7] = '{0, 3, 12, 0, 2, 1, 1};
    tbl[8] = '{1, 0, 16, 1, 0, 0, 0};

    #12;
    for (int i = 0; i < 3; i++) begin
      chk("rst_state", {busy[i], done[i], pass[i], fgot[i]}, 0);
      chk("rst_vals", {din[i], frow[i], ecnt[i]}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      md[tbl[i].inst] = 2'(tbl[i].mode);
      sbq.push_back(tbl[i]);
      run(tbl[i].inst, -1);
      @(negedge clk);
    end

    // start pulsed mid-run must not restart the check
    md[1] = 2'd0;
    sbq.push_back('{1, 0, 16, 1, 0, 0, 0});
    run(1, 5);
    @(negedge clk);

    // reset during WAIT of row 2 after two mismatches
    md[1] = 2'd1;
    st[1] = 1'b1;
    @(posedge clk);
    #1;
    st[1] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst_cnt", ecnt[1], 2);
    chk("pre_rst_din", din[1], 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {busy[1], done[1], pass[1]}, 0);
    chk("mid_rst_din", din[1], 0);
    chk("mid_rst_cnt", ecnt[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    md[1] = 2'd0;
    sbq.push_back('{1, 0, 16, 1, 0, 0, 0});
    run(1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
